fetch_line_prefetcher: RTL

- Write-side producer for the instruction fetch queue.
- Walks a line-aligned fetch PC and issues one 128-bit line request at a time to instruction memory.
- Captures each returned line and pushes it into the queue while the queue is not full.
- On a branch redirect, flushes the queue with the new word offset, discards any stale in-flight response, and restarts fetching at the new line.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_pc_gen.sv | 38 +++
 rtl/fetch_line_prefetcher.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared state encoding and line geometry for the fetch line prefetcher.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    PUSH,
    DRAIN
  } fetch_state_e;

  localparam int unsigned LINE_BYTES   = 16;
  localparam int unsigned OFFSET_WIDTH = 2;
  localparam int unsigned LINE_LSB     = 4;

endpackage

// File: rtl/fetch_pc_gen.sv
// Line-aligned fetch PC register: loads a redirect target or steps one line per push.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic [ADDR_WIDTH-LINE_LSB-1:0] load_line,
  input  logic                           inc,
  output logic [ADDR_WIDTH-1:0]          pc
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  // A redirect outranks the line step; the add wraps modulo 2^ADDR_WIDTH.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = {load_line, {LINE_LSB{1'b0}}};
    end else if (inc) begin
      pc_d = pc_q + ADDR_WIDTH'(LINE_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_line_prefetcher.sv
// Fetch-queue producer: requests one line at a time, pushes returned lines, and
// handles redirects by flushing the queue and dropping stale responses.
module fetch_line_prefetcher
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           LINE_WIDTH  = 128,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_en,
  input  logic                    redirect_valid,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic                    mem_resp_valid,
  input  logic [LINE_WIDTH-1:0]   mem_resp_data,
  output logic                    q_push,
  output logic [LINE_WIDTH-1:0]   q_data,
  input  logic                    q_full,
  output logic                    q_flush,
  output logic [OFFSET_WIDTH-1:0] q_offset,
  output logic [ADDR_WIDTH-1:0]   fetch_pc
);

  if (LINE_WIDTH != 4 * INSTR_WIDTH || RESET_PC[LINE_LSB-1:0] != '0) begin : g_bad_cfg
    $error("fetch_line_prefetcher: need LINE_WIDTH == 4*INSTR_WIDTH and aligned RESET_PC");
  end

  fetch_state_e            state_q, state_d;
  logic [LINE_WIDTH-1:0]   line_buf_q, line_buf_d;
  logic                    q_flush_q, q_flush_d;
  logic [OFFSET_WIDTH-1:0] q_offset_q, q_offset_d;
  logic                    pc_inc;

  // Byte-within-word bits of the redirect target carry no meaning here.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[LINE_LSB-OFFSET_WIDTH-1:0];

  always_comb begin
    state_d       = state_q;
    line_buf_d    = line_buf_q;
    q_flush_d     = redirect_valid;
    q_offset_d    = redirect_valid ? redirect_pc[LINE_LSB-1:LINE_LSB-OFFSET_WIDTH] : '0;
    mem_req_valid = 1'b0;
    q_push        = 1'b0;
    pc_inc        = 1'b0;

    unique case (state_q)
      REQ: begin
        mem_req_valid = fetch_en;
        // A request accepted alongside a redirect is already stale.
        if (fetch_en && mem_req_ready) begin
          state_d = redirect_valid ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          state_d = mem_resp_valid ? REQ : DRAIN;
        end else if (mem_resp_valid) begin
          line_buf_d = mem_resp_data;
          state_d    = PUSH;
        end
      end
      PUSH: begin
        if (redirect_valid) begin
          state_d = REQ;
        end else if (!q_full) begin
          q_push  = 1'b1;
          pc_inc  = 1'b1;
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (mem_resp_valid) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase

    if (!rst) begin
      mem_req_valid = 1'b0;
      q_push        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= REQ;
      line_buf_q <= '0;
      q_flush_q  <= 1'b0;
      q_offset_q <= '0;
    end else begin
      state_q    <= state_d;
      line_buf_q <= line_buf_d;
      q_flush_q  <= q_flush_d;
      q_offset_q <= q_offset_d;
    end
  end

  fetch_pc_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (redirect_valid),
    .load_line (redirect_pc[ADDR_WIDTH-1:LINE_LSB]),
    .inc       (pc_inc),
    .pc        (fetch_pc)
  );

  assign mem_req_addr = rst ? fetch_pc : '0;
  assign q_data       = line_buf_q;
  assign q_flush      = q_flush_q;
  assign q_offset     = q_offset_q;

  // Responses are only legal while a request is outstanding.
  resp_in_window: assert property (@(posedge clk) disable iff (!rst)
    mem_resp_valid |-> (state_q inside {WAIT, DRAIN}));

endmodule
